// File: rtl/systolic_tile_sequencer.sv
// Control sequencer for a weight-stationary systolic tile: weight load, double-buffered ifm compute, row write-back.
// Optional macro SYSTOLIC_TILE_SEQUENCER_PERF_CNT_EN adds stall_cycles/busy_cycles performance counters.
module systolic_tile_sequencer #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int KERNEL_SIZE   = 3,
    parameter int NO_CHANNEL    = 3,
    parameter int NO_FILTER     = 16,
    parameter int NO_TILE       = 10764,
    localparam int L_LEN  = KERNEL_SIZE * KERNEL_SIZE * NO_CHANNEL,
    localparam int P_LEN  = L_LEN + 2 * (SYSTOLIC_SIZE - 1),
    localparam int N_GRP  = (NO_FILTER + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE,
    localparam int ROW_W  = $clog2(SYSTOLIC_SIZE),
    localparam int TILE_W = (NO_TILE > 1) ? $clog2(NO_TILE) : 1,
    localparam int GRP_W  = (N_GRP > 1) ? $clog2(N_GRP) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              load_wgt,
    output logic              select_wgt,
    output logic              wgt_rf_valid,
    output logic              load_ifm,
    output logic              ifm_buf_wr_sel,
    output logic              ifm_buf_rd_sel,
    output logic              pe_en,
    output logic              reset_pe,
    output logic              wr_valid,
    output logic [1:0]        ifm_rf_valid,
    output logic [ROW_W-1:0]  wr_row,
    output logic [TILE_W-1:0] tile_idx,
    output logic [GRP_W-1:0]  filter_grp
`ifdef SYSTOLIC_TILE_SEQUENCER_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       busy_cycles
`endif
);

    localparam int CNT_W = $clog2(P_LEN + 1);

    localparam logic [CNT_W-1:0]  L_LAST = CNT_W'(L_LEN - 1);
    localparam logic [CNT_W-1:0]  L_CNT  = CNT_W'(L_LEN);
    localparam logic [CNT_W-1:0]  P_LAST = CNT_W'(P_LEN - 1);
    localparam logic [TILE_W-1:0] T_LAST = TILE_W'(NO_TILE - 1);
    localparam logic [GRP_W-1:0]  G_LAST = GRP_W'(N_GRP - 1);
    localparam logic [ROW_W-1:0]  R_LAST = ROW_W'(SYSTOLIC_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WGT,
        COMPUTE,
        WRITE,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TILE_W-1:0]  tile_q, tile_d;
    logic [GRP_W-1:0]   grp_q, grp_d;
    logic               wr_act_q, wr_act_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               stall;
    logic               phase_end;
    logic               last_row;
    logic               preload;

    assign stall     = wr_act_q & ~wr_ready;
    assign phase_end = (state_q == COMPUTE) && (cnt_q == P_LAST);
    assign last_row  = wr_act_q && (row_q == R_LAST);
    assign preload   = (tile_q != T_LAST) && (cnt_q < L_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tile_q   <= '0;
            grp_q    <= '0;
            wr_act_q <= 1'b0;
            row_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tile_q   <= tile_d;
            grp_q    <= grp_d;
            wr_act_q <= wr_act_d;
            row_q    <= row_d;
        end
    end

    // The write-back stream runs alongside the next phase, so it is sequenced independently of state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tile_d   = tile_q;
        grp_d    = grp_q;
        wr_act_d = wr_act_q;
        row_d    = row_q;
        if (!stall) begin
            if (phase_end) begin
                wr_act_d = 1'b1;
                row_d    = '0;
            end else if (wr_act_q) begin
                if (last_row) begin
                    wr_act_d = 1'b0;
                    row_d    = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LOAD_WGT;
                        cnt_d   = '0;
                        tile_d  = '0;
                        grp_d   = '0;
                    end
                end
                LOAD_WGT: begin
                    if (cnt_q == L_LAST) begin
                        state_d = COMPUTE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                COMPUTE: begin
                    if (phase_end) begin
                        cnt_d = '0;
                        if (tile_q == T_LAST) begin
                            state_d = WRITE;
                        end else begin
                            tile_d = tile_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WRITE: begin
                    if (last_row) begin
                        if (grp_q != G_LAST) begin
                            grp_d   = grp_q + 1'b1;
                            tile_d  = '0;
                            cnt_d   = '0;
                            state_d = LOAD_WGT;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    tile_d  = '0;
                    grp_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Tile t is read from buffer t%2 while tile t+1 is written into the other buffer.
    always_comb begin
        busy           = (state_q != IDLE);
        done           = (state_q == DONE);
        load_wgt       = 1'b0;
        select_wgt     = 1'b0;
        wgt_rf_valid   = 1'b0;
        load_ifm       = 1'b0;
        ifm_buf_wr_sel = 1'b0;
        ifm_buf_rd_sel = 1'b0;
        ifm_rf_valid   = 2'b00;
        pe_en          = 1'b0;
        reset_pe       = 1'b0;
        case (state_q)
            LOAD_WGT: begin
                load_wgt     = 1'b1;
                select_wgt   = 1'b1;
                wgt_rf_valid = 1'b1;
                load_ifm     = 1'b1;
                ifm_rf_valid = 2'b01;
            end
            COMPUTE: begin
                pe_en          = 1'b1;
                ifm_buf_rd_sel = tile_q[0];
                ifm_buf_wr_sel = ~tile_q[0];
                ifm_rf_valid   = tile_q[0] ? 2'b10 : 2'b01;
                reset_pe       = (cnt_q == P_LAST);
                if (preload) begin
                    load_ifm     = 1'b1;
                    ifm_rf_valid = 2'b11;
                end
            end
            default: ;
        endcase
        if (stall) begin
            load_wgt     = 1'b0;
            wgt_rf_valid = 1'b0;
            load_ifm     = 1'b0;
            ifm_rf_valid = 2'b00;
            pe_en        = 1'b0;
            reset_pe     = 1'b0;
        end
    end

    assign wr_valid   = wr_act_q;
    assign wr_row     = row_q;
    assign tile_idx   = tile_q;
    assign filter_grp = grp_q;

`ifdef SYSTOLIC_TILE_SEQUENCER_PERF_CNT_EN
    // Counters restart on each accepted run and stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            busy_cycles  <= '0;
        end else if ((state_q == IDLE) && start) begin
            stall_cycles <= '0;
            busy_cycles  <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (busy && (busy_cycles != '1)) begin
                busy_cycles <= busy_cycles + 1'b1;
            end
        end
    end
`endif

endmodule
